// File: rtl/mul_arbiter.sv
// mul_arbiter: shares one sequential shift-add multiplier between NUM_REQ
// requesters. Round-robin grant, a single operation in flight, and each
// product routed back to the requester that issued it.
// Optional build macro MUL_ARB_ZERO_BYPASS_EN: a granted request with a zero
// operand skips the multiplier and responds with a zero product directly.
module mul_arbiter #(
   parameter int LEN     = 32,
   parameter int NUM_REQ = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   output logic [NUM_REQ-1:0]     req_ready,
   input  logic [NUM_REQ*LEN-1:0] req_a,
   input  logic [NUM_REQ*LEN-1:0] req_b,
   output logic [NUM_REQ-1:0]     rsp_valid,
   input  logic [NUM_REQ-1:0]     rsp_ready,
   output logic [2*LEN-1:0]       rsp_product,
   output logic [LEN-1:0]         mul_multiplicand,
   output logic [LEN-1:0]         mul_multiplier,
   output logic                   mul_start,
   input  logic [2*LEN-1:0]       mul_product,
   input  logic                   mul_finish,
   output logic [31:0]            done_count
);

   localparam int ID_W = $clog2(NUM_REQ);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   id_q, id_d;
   logic [LEN-1:0]    a_q, a_d;
   logic [LEN-1:0]    b_q, b_d;
   logic [2*LEN-1:0]  result_q, result_d;
   logic [31:0]       done_count_q, done_count_d;

   logic              grant_found;
   logic [ID_W-1:0]   grant_id;
   logic [LEN-1:0]    grant_a;
   logic [LEN-1:0]    grant_b;
   logic              rsp_fire;

   // Round-robin search: first valid requester at or above rr_ptr, wrapping.
   always_comb begin
      logic [ID_W:0]   idx_wide;
      logic [ID_W-1:0] idx;
      // NOTE: every signal written in a combinational block gets a default
      // first, so no path leaves it unassigned and no latch is inferred.
      grant_found = 1'b0;
      grant_id    = '0;
      idx_wide    = '0;
      idx         = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         idx_wide = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
         if (idx_wide >= (ID_W+1)'(NUM_REQ)) begin
            idx_wide = idx_wide - (ID_W+1)'(NUM_REQ);
         end
         idx = idx_wide[ID_W-1:0];
         if (!grant_found && req_valid[idx]) begin
            grant_found = 1'b1;
            grant_id    = idx;
         end
      end
   end

   assign grant_a  = req_a[grant_id*LEN +: LEN];
   assign grant_b  = req_b[grant_id*LEN +: LEN];
   assign rsp_fire = (state_q == RESP) && rsp_ready[id_q];

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: every control and datapath register is reset so that outputs
      // are defined zeros immediately; a reset mid-operation leaves nothing
      // stale behind.
      if (rst) begin
         state_q      <= IDLE;
         rr_ptr_q     <= '0;
         id_q         <= '0;
         a_q          <= '0;
         b_q          <= '0;
         result_q     <= '0;
         done_count_q <= '0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples the
         // pre-edge value of every other, independent of statement order.
         state_q      <= state_d;
         rr_ptr_q     <= rr_ptr_d;
         id_q         <= id_d;
         a_q          <= a_d;
         b_q          <= b_d;
         result_q     <= result_d;
         done_count_q <= done_count_d;
      end
   end

   // Next-state and datapath update logic.
   always_comb begin
      state_d      = state_q;
      rr_ptr_d     = rr_ptr_q;
      id_d         = id_q;
      a_d          = a_q;
      b_d          = b_q;
      result_d     = result_q;
      done_count_d = done_count_q;
      case (state_q)
         IDLE: begin
            if (grant_found) begin
               a_d      = grant_a;
               b_d      = grant_b;
               id_d     = grant_id;
               rr_ptr_d = (grant_id == ID_W'(NUM_REQ-1)) ? '0 : grant_id + ID_W'(1);
               state_d  = ISSUE;
`ifdef MUL_ARB_ZERO_BYPASS_EN
               // A zero operand has a known product; skip the multiplier.
               if ((grant_a == '0) || (grant_b == '0)) begin
                  result_d = '0;
                  state_d  = RESP;
               end
`endif
            end
         end
         ISSUE: state_d = BUSY;
         BUSY: begin
            if (mul_finish) begin
               result_d = mul_product;
               state_d  = RESP;
            end
         end
         RESP: begin
            // Only the owning requester's ready completes the response.
            if (rsp_fire) begin
               done_count_d = done_count_q + 32'd1;
               state_d      = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Handshake outputs decoded from the current state.
   always_comb begin
      req_ready = '0;
      rsp_valid = '0;
      mul_start = 1'b0;
      case (state_q)
         IDLE:    if (grant_found && !rst) req_ready[grant_id] = 1'b1;
         ISSUE:   mul_start = 1'b1;
         RESP:    rsp_valid[id_q] = 1'b1;
         default: ;
      endcase
   end

   assign rsp_product      = result_q;
   assign mul_multiplicand = a_q;
   assign mul_multiplier   = b_q;
   assign done_count       = done_count_q;

endmodule

// File: doc/mul_arbiter.md
Name: mul_arbiter

Overview:
- Shares one sequential shift-add multiplier between NUM_REQ requesters.
- Round-robin arbitration; keeps only one operation in flight.
- Sequences the multiplier's start/finish handshake and routes each product back to the requester that issued it.
- Sits between requester blocks and the single multiplier instance.

Parameters:
- LEN, 32, operand width; product width is 2*LEN.
- NUM_REQ, 4, number of requesters (2..16).
- ID_W, $clog2(NUM_REQ), derived local width of the grant index.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  one-hot request accept, combinational
- req_a  input  NUM_REQ*LEN  packed multiplicands; requester i occupies [i*LEN +: LEN]
- req_b  input  NUM_REQ*LEN  packed multipliers, same packing
- rsp_valid  output  NUM_REQ  one-hot response valid
- rsp_ready  input  NUM_REQ  per-requester response accept
- rsp_product  output  2*LEN  product for the requester flagged in rsp_valid
- mul_multiplicand  output  LEN  to multiplier
- mul_multiplier  output  LEN  to multiplier
- mul_start  output  1  to multiplier, one-cycle pulse
- mul_product  input  2*LEN  from multiplier
- mul_finish  input  1  from multiplier
- done_count  output  32  completed operations, wraps modulo 2^32

Behaviour:
- Reset (async, rst=1): state IDLE, rr_ptr=0, all outputs 0, operand/result/id registers 0.
- States: IDLE, ISSUE, BUSY, RESP.
- IDLE:
  - If any req_valid is high, the grant g is the first valid index found searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - On that edge: latch req_a[g] and req_b[g] into the operand registers, latch g into the id register, set rr_ptr=(g+1) mod NUM_REQ, go to ISSUE.
  - With no req_valid high: stay in IDLE; req_ready=0.
- ISSUE: mul_start=1 for exactly this one cycle, then go to BUSY.
- BUSY: mul_start=0. On the first cycle with mul_finish=1, capture mul_product into the result register and go to RESP.
- RESP:
  - rsp_valid[id]=1 and rsp_product=result register, both held stable until rsp_ready[id]=1.
  - On that handshake: done_count+1, go to IDLE.
  - rsp_ready bits of other requesters are ignored.
- mul_multiplicand and mul_multiplier are driven from the operand registers at all times, so they are stable from ISSUE through BUSY.
- rsp_valid=0 outside RESP. rsp_product holds the last result.
- Latency, measured from accept edge T:
  - mul_start is high during cycle T+1.
  - rsp_valid rises on the cycle after mul_finish is sampled high.
- Throughput: at most one operation outstanding. No new accept in ISSUE, BUSY or RESP. A new accept is possible in the cycle after the RESP handshake.
- Simultaneous events:
  - A request arriving during RESP waits; it is not granted in the same cycle as the response handshake.
  - A requester may keep req_valid high across its own response; it then re-arbitrates with its rr_ptr priority already rotated away.
- mul_finish seen in IDLE, ISSUE or RESP: ignored.
- Reset mid-operation: the in-flight operation is abandoned with no response. The multiplier shares rst, so it also returns to idle. The next request completes normally.
- Requesters must hold req_a/req_b stable while req_valid is high; values are sampled only at the accept edge.

Optional Feature:
- Macro: MUL_ARB_ZERO_BYPASS_EN.
- Defined:
  - In IDLE, if the granted request has req_a[g]==0 or req_b[g]==0, go directly to RESP with result=0.
  - mul_start is not pulsed.
  - rsp_valid rises at T+1.
  - done_count still increments on the handshake.
- Undefined: every operation, including zero operands, goes through ISSUE/BUSY.

Test Plan (LEN=8, NUM_REQ=4):
- Single request, id 2, a=5, b=7: req_ready[2] pulses once, mul_start pulses once at T+1, rsp_valid=4'b0100 with rsp_product=35, done_count=1.
- Requests 0..3 all held valid from reset, ten operations: grant order 0,1,2,3,0,1,2,3,0,1; each response lands on the matching rsp_valid bit with its correct product.
- Back-pressure, id 1 with a=255, b=255, rsp_ready[1] low for 6 cycles: rsp_valid[1] and rsp_product=65025 held stable; req_ready stays 0 despite a pending req_valid[3]; id 3 is accepted the cycle after the handshake.
- rst asserted for 2 cycles during BUSY: all outputs 0 immediately, done_count=0; a following request a=12, b=11 on id 0 returns 132.
- Zero operand, id 3, a=0, b=200:
  - With MUL_ARB_ZERO_BYPASS_EN: no mul_start, rsp_valid[3] at T+1, product 0.
  - Without it: normal multiplier path, product 0.
- Spurious mul_finish=1 injected in IDLE: no response generated, no state change, done_count unchanged.
